// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, funct codes,
// ALU operation codes, datapath select encodings and the FSM state type.
`timescale 1ns/1ps
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [1:0] {
    SRCB_REG     = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alusrcb_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsrc_e;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

endpackage

// File: rtl/mips_multicycle_controller_alu_decoder.sv
// ALU control decoder: maps (aluop, funct) to the ALU operation and flags
// R-type funct codes the datapath cannot execute.
`timescale 1ns/1ps
module mc_alu_decoder
  import mips_mc_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  logic [5:0]           funct,
  input  logic [1:0]           aluop,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 funct_ok
);

  logic [2:0] code;

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    code     = ALUC_ADD;
    funct_ok = 1'b1;
    case (aluop)
      ALUOP_SUB: code = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: code = ALUC_ADD;
          FUNCT_SUB: code = ALUC_SUB;
          FUNCT_AND: code = ALUC_AND;
          FUNCT_OR:  code = ALUC_OR;
          FUNCT_SLT: code = ALUC_SLT;
          default:   funct_ok = 1'b0;
        endcase
      end
      default: code = ALUC_ADD;
    endcase
  end

  assign alucontrol = ALUCTRL_W'(code);

endmodule

// File: rtl/mips_multicycle_controller.sv
// Moore FSM sequencing MIPS instructions over the shared-ALU/shared-memory
// multicycle datapath, with a variable-latency memory handshake.
`timescale 1ns/1ps
module mips_multicycle_controller
  import mips_mc_pkg::*;
#(
  parameter int ALUCTRL_W     = 3,
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit SUPPORT_BNE   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 memready,
  output logic                 memreq,
  output logic                 iord,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 regwrite,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic [1:0]           pcsrc,
  output logic                 pcen,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 illegal,
  output logic [3:0]           state
);

  state_e   state_q, state_d;
  alusrcb_e alusrcb_c;
  pcsrc_e   pcsrc_c;
  logic [1:0] aluop;
  logic ready, funct_ok;
  logic memreq_c, memwrite_c, irwrite_c, regwrite_c;
  logic pcwrite, branch, bne, illegal_c;

  assign ready = MEM_HANDSHAKE ? memready : 1'b1;

  mc_alu_decoder #(.ALUCTRL_W(ALUCTRL_W)) u_alu_decoder (
    .funct      (funct),
    .aluop      (aluop),
    .alucontrol (alucontrol),
    .funct_ok   (funct_ok)
  );

  // NOTE: state registers use non-blocking assignment so every flop samples
  // its input from before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    memreq_c   = 1'b0;
    iord       = 1'b0;
    memwrite_c = 1'b0;
    irwrite_c  = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite_c = 1'b0;
    alusrca    = 1'b0;
    alusrcb_c  = SRCB_REG;
    pcsrc_c    = PCSRC_ALU;
    aluop      = ALUOP_ADD;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    bne        = 1'b0;
    case (state_q)
      S_FETCH: begin
        memreq_c  = 1'b1;
        alusrcb_c = SRCB_FOUR;
        irwrite_c = ready;
        pcwrite   = ready;
      end
      S_DECODE: alusrcb_c = SRCB_IMM_SH2;
      S_MEMADR: begin
        alusrca   = 1'b1;
        alusrcb_c = SRCB_IMM;
      end
      S_MEMRD: begin
        memreq_c = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_c = 1'b1;
      end
      // Write strobe is held for the whole wait so slow memories see it stable.
      S_MEMWR: begin
        memreq_c   = 1'b1;
        iord       = 1'b1;
        memwrite_c = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite_c = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc_c = PCSRC_ALUOUT;
        branch  = (op == OP_BEQ);
        bne     = SUPPORT_BNE && (op == OP_BNE);
      end
      S_ADDIEX: begin
        alusrca   = 1'b1;
        alusrcb_c = SRCB_IMM;
      end
      S_ADDIWB: regwrite_c = 1'b1;
      S_JUMP: begin
        pcsrc_c = PCSRC_JUMP;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    illegal_c = 1'b0;
    case (state_q)
      S_FETCH: if (ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_BNE: begin
            if (SUPPORT_BNE) begin
              state_d = S_BRANCH;
            end else begin
              state_d   = S_FETCH;
              illegal_c = 1'b1;
            end
          end
          OP_ADDI: state_d = S_ADDIEX;
          OP_J:    state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_c = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (ready) state_d = S_MEMWB;
      S_MEMWR:  if (ready) state_d = S_FETCH;
      S_EXECUTE: begin
        if (funct_ok) begin
          state_d = S_ALUWB;
        end else begin
          state_d   = S_FETCH;
          illegal_c = 1'b1;
        end
      end
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // FETCH requests memory, so strobes are masked directly while reset is high.
  assign memreq   = memreq_c   & ~reset;
  assign memwrite = memwrite_c & ~reset;
  assign irwrite  = irwrite_c  & ~reset;
  assign regwrite = regwrite_c & ~reset;
  assign pcen     = (pcwrite | (branch & zero) | (bne & ~zero)) & ~reset;
  assign illegal  = illegal_c  & ~reset;
  assign alusrcb  = alusrcb_c;
  assign pcsrc    = pcsrc_c;
  assign state    = state_q;

endmodule
